// File: rtl/hazard_unit.sv
// hazard_unit: stall and D-stage forwarding control for the five-stage MIPS core.
//
// Tracks the destination register and remaining result latency (Tnew) of the
// instructions in E, M and W, and compares them against the operand need-times
// (Tuse) of the instruction sitting in D.
//
// Optional feature: define HAZARD_MD_EN to add the mult/div busy counter and
// its stall term. Without it the md_* ports and MD_* parameters are ignored.
//
// Handshake: there is no valid/ready pair here. stall is a combinational
// request to datapath; en_pc and en_fd are its complement, and a stalled cycle
// inserts a bubble into D/E in both datapath and this scoreboard.
module hazard_unit #(
  parameter int MD_MULT_CYC = 5,
  parameter int MD_DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] a3_d,
  input  logic [1:0] tnew_d,
  input  logic       md_start_d,
  input  logic       md_div_d,
  input  logic       md_use_d,
  output logic       stall,
  output logic       en_pc,
  output logic       en_fd,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d
);

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_M     = 2'd1;
  localparam logic [1:0] FWD_W     = 2'd2;

  // Scoreboard of in-flight producers
  logic [4:0] a3_e;
  logic [4:0] a3_m;
  logic [4:0] a3_w;
  logic [1:0] tnew_e;
  logic [1:0] tnew_m;

  logic       conflict_rs;
  logic       conflict_rt;
  logic       md_stall;

  // A source operand must wait if a younger producer cannot deliver in time.
  function automatic logic conflict_of(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_a3,
    input logic [1:0] e_tnew,
    input logic [4:0] m_a3,
    input logic [1:0] m_tnew
  );
    logic hit;
    hit = 1'b0;
    if ((src != 5'd0) && (tuse != TUSE_NONE)) begin
      if ((src == e_a3) && (e_tnew > tuse)) hit = 1'b1;
      if ((src == m_a3) && (m_tnew > tuse)) hit = 1'b1;
    end
    return hit;
  endfunction

  // M has priority over W because it holds the younger producer. E is never a
  // source: a Tnew=0 value in E is picked up from M one cycle later.
  function automatic logic [1:0] fwd_of(
    input logic [4:0] src,
    input logic [4:0] m_a3,
    input logic [1:0] m_tnew,
    input logic [4:0] w_a3
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if ((src != 5'd0) && (src == m_a3) && (m_tnew == 2'd0)) sel = FWD_M;
    else if ((src != 5'd0) && (src == w_a3)) sel = FWD_W;
    return sel;
  endfunction

  // Per-operand conflict detection and overall stall/enable generation
  always_comb begin
    conflict_rs = conflict_of(rs_d, tuse_rs_d, a3_e, tnew_e, a3_m, tnew_m);
    conflict_rt = conflict_of(rt_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m);
    stall       = conflict_rs | conflict_rt | md_stall;
    en_pc       = ~stall;
    en_fd       = ~stall;
  end

  // D-stage comparator forwarding selects
  always_comb begin
    fwd_rs_d = fwd_of(rs_d, a3_m, tnew_m, a3_w);
    fwd_rt_d = fwd_of(rt_d, a3_m, tnew_m, a3_w);
  end

  // Scoreboard advance: a stall turns the D->E slot into a bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      a3_e   <= 5'd0;
      tnew_e <= 2'd0;
      a3_m   <= 5'd0;
      tnew_m <= 2'd0;
      a3_w   <= 5'd0;
    end else begin
      if (stall) begin
        a3_e   <= 5'd0;
        tnew_e <= 2'd0;
      end else begin
        a3_e   <= a3_d;
        tnew_e <= tnew_d;
      end
      a3_m   <= a3_e;
      tnew_m <= (tnew_e == 2'd0) ? 2'd0 : (tnew_e - 2'd1);
      a3_w   <= a3_m;
    end
  end

`ifdef HAZARD_MD_EN
  logic [3:0] md_cnt;
  logic       md_start_e;
  logic       md_div_e;

  // Mult/div in E loads the busy counter; otherwise it counts down to zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      md_cnt     <= 4'd0;
      md_start_e <= 1'b0;
      md_div_e   <= 1'b0;
    end else begin
      if (stall) begin
        md_start_e <= 1'b0;
        md_div_e   <= 1'b0;
      end else begin
        md_start_e <= md_start_d;
        md_div_e   <= md_div_d;
      end
      if (md_start_e) md_cnt <= md_div_e ? 4'(MD_DIV_CYC) : 4'(MD_MULT_CYC);
      else if (md_cnt != 4'd0) md_cnt <= md_cnt - 4'd1;
    end
  end

  // HI/LO users wait while the unit is busy or a start is still in E
  always_comb begin
    md_stall = md_use_d & ((md_cnt != 4'd0) | md_start_e);
  end
`else
  logic unused_md;
  localparam int UNUSED_MD_CYC = MD_MULT_CYC + MD_DIV_CYC;

  // No mult/div unit in this build: no extra stall source
  always_comb begin
    md_stall  = 1'b0;
    unused_md = ^{md_start_d, md_div_d, md_use_d, UNUSED_MD_CYC[0]};
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed bench for hazard_unit with an expected-value queue.
// Exercises the mult/div path too when HAZARD_MD_EN is defined.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;
  logic [4:0] a3_d;
  logic [1:0] tnew_d;
  logic       md_start_d;
  logic       md_div_d;
  logic       md_use_d;
  logic       stall;
  logic       en_pc;
  logic       en_fd;
  logic [1:0] fwd_rs_d;
  logic [1:0] fwd_rt_d;

  // {stall, en_pc, en_fd, fwd_rs_d, fwd_rt_d}
  logic [6:0] exp_q[$];
  int         pass_cnt;
  int         total_cnt;

  hazard_unit dut (
    .clk        (clk),
    .rst        (rst),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .tuse_rs_d  (tuse_rs_d),
    .tuse_rt_d  (tuse_rt_d),
    .a3_d       (a3_d),
    .tnew_d     (tnew_d),
    .md_start_d (md_start_d),
    .md_div_d   (md_div_d),
    .md_use_d   (md_use_d),
    .stall      (stall),
    .en_pc      (en_pc),
    .en_fd      (en_fd),
    .fwd_rs_d   (fwd_rs_d),
    .fwd_rt_d   (fwd_rt_d)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One D-stage cycle: drive inputs, queue the expectation, compare on the
  // falling edge, then advance past the next rising edge.
  task automatic step(input string tag,
                      input logic [4:0] rs, input logic [1:0] tu_rs,
                      input logic [4:0] rt, input logic [1:0] tu_rt,
                      input logic [4:0] a3, input logic [1:0] tn,
                      input logic e_stall, input logic [1:0] e_frs,
                      input logic [1:0] e_frt);
    logic [6:0] e;
    rs_d      = rs;
    tuse_rs_d = tu_rs;
    rt_d      = rt;
    tuse_rt_d = tu_rt;
    a3_d      = a3;
    tnew_d    = tn;
    exp_q.push_back({e_stall, ~e_stall, ~e_stall, e_frs, e_frt});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      cmp({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      cmp(tag, {25'd0, stall, en_pc, en_fd, fwd_rs_d, fwd_rt_d}, {25'd0, e});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    md_start_d = 1'b0;
    md_div_d   = 1'b0;
    md_use_d   = 1'b0;
    rst        = 1'b0;

    // Reset with idle D inputs
    step("rst_idle0", 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    step("rst_idle1", 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    cmp("rst_scoreboard", {13'd0, dut.a3_e, dut.tnew_e, dut.a3_m, dut.tnew_m, dut.a3_w}, 32'd0);
    rst = 1'b1;

    // Load $8, dependent ALU op: one stall, then W forward, then regfile
    step("lu_load",   5'd0, 2'd3, 5'd0,  2'd3, 5'd8,  2'd2, 1'b0, 2'd0, 2'd0);
    step("lu_stall",  5'd8, 2'd1, 5'd0,  2'd3, 5'd10, 2'd1, 1'b1, 2'd0, 2'd0);
    step("lu_go",     5'd8, 2'd1, 5'd0,  2'd3, 5'd10, 2'd1, 1'b0, 2'd0, 2'd0);
    step("lu_fwd_w",  5'd8, 2'd1, 5'd0,  2'd3, 5'd0,  2'd0, 1'b0, 2'd2, 2'd0);
    step("lu_rf_fm",  5'd8, 2'd1, 5'd10, 2'd0, 5'd0,  2'd0, 1'b0, 2'd0, 2'd1);

    // ALU writes $9, dependent beq: one stall, then M forward, then W
    step("br_alu",    5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd1, 1'b0, 2'd0, 2'd0);
    step("br_stall",  5'd9, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0, 1'b1, 2'd0, 2'd0);
    step("br_fwd_m",  5'd9, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0, 1'b0, 2'd1, 2'd1);
    step("br_fwd_w",  5'd9, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 2'd2, 2'd0);

    // Register $0 never stalls or forwards
    step("r0_write",  5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 2'd0, 2'd0);
    step("r0_read0",  5'd0, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    step("r0_read1",  5'd0, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0);

    // $5 produced twice: M wins over W
    step("mw_prod0",  5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 2'd0, 2'd0);
    step("mw_prod1",  5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 2'd0, 2'd0);
    step("mw_m_only", 5'd5, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 2'd1, 2'd0);
    step("mw_both",   5'd5, 2'd1, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 2'd1, 2'd1);
    step("mw_w_only", 5'd5, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 2'd2, 2'd0);

    // Load $8, dependent branch: two stalls, then W forward
    step("lb_load",   5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0, 2'd0, 2'd0);
    step("lb_stall0", 5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 2'd0, 2'd0);
    step("lb_stall1", 5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 2'd0, 2'd0);
    step("lb_fwd_w",  5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 2'd2, 2'd0);

    // Reset asserted during a load-use stall clears the scoreboard
    step("rs_load",   5'd0,  2'd3, 5'd0, 2'd3, 5'd12, 2'd2, 1'b0, 2'd0, 2'd0);
    rst = 1'b0;
    step("rs_stall",  5'd12, 2'd1, 5'd0, 2'd3, 5'd0,  2'd0, 1'b1, 2'd0, 2'd0);
    cmp("rs_scoreboard", {13'd0, dut.a3_e, dut.tnew_e, dut.a3_m, dut.tnew_m, dut.a3_w}, 32'd0);
    step("rs_clear",  5'd12, 2'd1, 5'd0, 2'd3, 5'd0,  2'd0, 1'b0, 2'd0, 2'd0);
    rst = 1'b1;
    step("rs_resume", 5'd12, 2'd1, 5'd0, 2'd3, 5'd0,  2'd0, 1'b0, 2'd0, 2'd0);

`ifdef HAZARD_MD_EN
    // div followed immediately by mflo: 1 cycle for E plus 10 busy cycles
    md_start_d = 1'b1;
    md_div_d   = 1'b1;
    md_use_d   = 1'b1;
    step("md_div", 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    md_start_d = 1'b0;
    md_div_d   = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step($sformatf("md_busy%0d", i), 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 2'd0, 2'd0);
    end
    step("md_release", 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    md_use_d = 1'b0;
`endif

    cmp("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
